// File: rtl/gshare_branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB for targets plus a PHT of
// saturating counters for direction, with a speculative global history (GHR).
// Optional feature macro: BP_GSHARE_EN. When it is defined, the PHT index is
// PC XOR history. When it is not defined, the PHT is indexed by the PC alone
// (bimodal), and the GHR and recovery logic are still present and active.
module gshare_branch_predictor #(
  parameter int unsigned BTB_INDEX_BITS = 8,
  parameter int unsigned PHT_INDEX_BITS = 10,
  parameter int unsigned HIST_BITS      = 8,
  parameter int unsigned CTR_BITS       = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_fetch_valid,
  input  logic [31:0]          i_fetch_pc,
  output logic                 o_predict_taken,
  output logic [31:0]          o_predict_target,
  output logic [HIST_BITS-1:0] o_predict_hist,
  input  logic                 i_update_en,
  input  logic [31:0]          i_update_pc,
  input  logic [HIST_BITS-1:0] i_update_hist,
  input  logic                 i_actual_taken,
  input  logic [31:0]          i_actual_target,
  input  logic                 i_update_mispredict,
  output logic [31:0]          o_stat_updates,
  output logic [31:0]          o_stat_mispredicts
);

  localparam int BtbEntries = 1 << BTB_INDEX_BITS;
  localparam int PhtEntries = 1 << PHT_INDEX_BITS;
  localparam int TagBits    = 30 - BTB_INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CtrMax  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic                      r_btb_valid  [BtbEntries];
  logic [TagBits-1:0]        r_btb_tag    [BtbEntries];
  logic [31:0]               r_btb_target [BtbEntries];
  logic [CTR_BITS-1:0]       r_pht        [PhtEntries];
  logic [HIST_BITS-1:0]      r_ghr;
  logic [31:0]               r_stat_updates;
  logic [31:0]               r_stat_mispredicts;

  logic [BTB_INDEX_BITS-1:0] w_fetch_bi;
  logic [TagBits-1:0]        w_fetch_tag;
  logic [PHT_INDEX_BITS-1:0] w_fetch_pi;
  logic [BTB_INDEX_BITS-1:0] w_upd_bi;
  logic [TagBits-1:0]        w_upd_tag;
  logic [PHT_INDEX_BITS-1:0] w_upd_pi;
  logic                      w_hit;
  logic [CTR_BITS-1:0]       w_fetch_ctr;
  logic                      w_taken;
  logic [CTR_BITS-1:0]       w_upd_ctr;
  logic [CTR_BITS-1:0]       w_upd_ctr_next;
  logic                      w_unused_bits;

  assign w_fetch_bi  = i_fetch_pc[BTB_INDEX_BITS+1:2];
  assign w_fetch_tag = i_fetch_pc[31:BTB_INDEX_BITS+2];
  assign w_upd_bi    = i_update_pc[BTB_INDEX_BITS+1:2];
  assign w_upd_tag   = i_update_pc[31:BTB_INDEX_BITS+2];

`ifdef BP_GSHARE_EN
  assign w_fetch_pi = i_fetch_pc[PHT_INDEX_BITS+1:2] ^ PHT_INDEX_BITS'(r_ghr);
  assign w_upd_pi   = i_update_pc[PHT_INDEX_BITS+1:2] ^ PHT_INDEX_BITS'(i_update_hist);
`else
  assign w_fetch_pi = i_fetch_pc[PHT_INDEX_BITS+1:2];
  assign w_upd_pi   = i_update_pc[PHT_INDEX_BITS+1:2];
`endif

  // Byte-offset bits never participate in any index or tag.
  assign w_unused_bits = ^{i_fetch_pc[1:0], i_update_pc[1:0]};

  assign w_hit       = r_btb_valid[w_fetch_bi] && (r_btb_tag[w_fetch_bi] == w_fetch_tag);
  assign w_fetch_ctr = r_pht[w_fetch_pi];
  assign w_taken     = w_hit & w_fetch_ctr[CTR_BITS-1];

  assign o_predict_taken    = w_taken;
  assign o_predict_target   = w_taken ? r_btb_target[w_fetch_bi] : 32'd0;
  assign o_predict_hist     = r_ghr;
  assign o_stat_updates     = r_stat_updates;
  assign o_stat_mispredicts = r_stat_mispredicts;

  assign w_upd_ctr = r_pht[w_upd_pi];

  // Saturating counter step toward the resolved direction.
  always_comb begin
    w_upd_ctr_next = w_upd_ctr;
    if (i_actual_taken) begin
      if (w_upd_ctr != CtrMax) w_upd_ctr_next = w_upd_ctr + CTR_BITS'(1);
    end else begin
      if (w_upd_ctr != '0) w_upd_ctr_next = w_upd_ctr - CTR_BITS'(1);
    end
  end

  // BTB and PHT writeback; a not-taken resolution leaves the BTB untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < BtbEntries; i++) begin
        r_btb_valid[i]  <= 1'b0;
        r_btb_tag[i]    <= '0;
        r_btb_target[i] <= '0;
      end
      for (int i = 0; i < PhtEntries; i++) begin
        r_pht[i] <= CtrInit;
      end
    end else if (i_update_en) begin
      r_pht[w_upd_pi] <= w_upd_ctr_next;
      if (i_actual_taken) begin
        r_btb_valid[w_upd_bi]  <= 1'b1;
        r_btb_tag[w_upd_bi]    <= w_upd_tag;
        r_btb_target[w_upd_bi] <= i_actual_target;
      end
    end
  end

  // GHR: recovery from the carried snapshot beats the speculative fetch shift.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ghr <= '0;
    end else if (i_update_en && i_update_mispredict) begin
      r_ghr <= HIST_BITS'({i_update_hist, i_actual_taken});
    end else if (i_fetch_valid && w_hit) begin
      r_ghr <= HIST_BITS'({r_ghr, w_taken});
    end
  end

  // Free-running statistics, wrapping modulo 2^32.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_updates     <= '0;
      r_stat_mispredicts <= '0;
    end else if (i_update_en) begin
      r_stat_updates <= r_stat_updates + 32'd1;
      if (i_update_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

endmodule
